// File: rtl/cnn_pkg.sv
// Shared constants for the CNN streaming stages: Q-format defaults,
// saturation limits and coefficient-file addresses.
package cnn_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FRAC_BITS  = 16;

  localparam longint ONE_Q   = 64'sd1 <<< DEF_FRAC_BITS;
  localparam longint SAT_MAX = (64'sd1 <<< (DEF_DATA_WIDTH - 1)) - 64'sd1;
  localparam longint SAT_MIN = -(64'sd1 <<< (DEF_DATA_WIDTH - 1));

  localparam logic [3:0] W_ADDR_CENTRE = 4'd4;
  localparam logic [3:0] W_ADDR_BIAS   = 4'd9;

endpackage

// File: rtl/conv_line_buffer.sv
// Enable-gated shift register holding one image row; the tap is the pixel
// accepted exactly DEPTH enables ago.
module conv_line_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with bias, saturation and ReLU; emits one result
// per complete (unpadded) window, two cycles after the completing pixel.
module conv3x3_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  data_valid_in,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  W_WE,
  input  logic [3:0]            W_ADDR,
  input  logic [DATA_WIDTH-1:0] W_DATA,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  data_valid_out,
  output logic                  frame_done
);

  localparam int SW = DATA_WIDTH + 4;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic signed [SW-1:0] L_MAX = {{5{1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  logic [CW-1:0]                r_col;
  logic [RW-1:0]                r_row;
  logic signed [DATA_WIDTH-1:0] r_win      [3][3];
  logic signed [DATA_WIDTH-1:0] w_win_next [3][3];
  logic [DATA_WIDTH-1:0]        w_lb1_out;
  logic [DATA_WIDTH-1:0]        w_lb2_out;
  logic signed [DATA_WIDTH-1:0] r_coef [9];
  logic signed [DATA_WIDTH-1:0] r_bias;
  logic signed [SW-1:0]         r_prod [9];
  logic signed [DATA_WIDTH-1:0] r_s1_bias;
  logic                         r_s1_valid;
  logic                         r_s1_last;
  logic signed [SW-1:0]         w_sum;
  logic [DATA_WIDTH-1:0]        w_result;
  logic                         w_col_last;
  logic                         w_row_last;
  logic                         w_win_valid;
  logic                         w_frame_last;

  assign w_col_last   = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_last   = (r_row == RW'(IMG_HEIGHT - 1));
  assign w_win_valid  = data_valid_in && (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_frame_last = w_win_valid && w_row_last && w_col_last;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_col <= '0;
      r_row <= '0;
    end else if (data_valid_in) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  conv_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb_row1 (
    .i_clk (CLK),
    .i_en  (data_valid_in),
    .i_data(DATA_IN),
    .o_data(w_lb1_out)
  );

  conv_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb_row2 (
    .i_clk (CLK),
    .i_en  (data_valid_in),
    .i_data(w_lb1_out),
    .o_data(w_lb2_out)
  );

  // The window as it will look once the current pixel is accepted; stage 1
  // multiplies this directly so the result lands two cycles after acceptance.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_win_next[r][0] = r_win[r][1];
      w_win_next[r][1] = r_win[r][2];
    end
    w_win_next[0][2] = w_lb2_out;
    w_win_next[1][2] = w_lb1_out;
    w_win_next[2][2] = DATA_IN;
  end

  always_ff @(posedge CLK) begin
    if (data_valid_in) begin
      r_win <= w_win_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int k = 0; k < 9; k++) begin
        r_coef[k] <= '0;
      end
      r_bias <= '0;
    end else if (W_WE) begin
      for (int k = 0; k < 9; k++) begin
        if (W_ADDR == 4'(k)) begin
          r_coef[k] <= W_DATA;
        end
      end
      if (W_ADDR == W_ADDR_BIAS) begin
        r_bias <= W_DATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_win_valid;
      r_s1_last  <= w_frame_last;
    end
  end

  // Products keep only the low SW bits after the Q shift; the adder wraps there.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < 9; k++) begin
      r_prod[k] <= SW'((PW'(w_win_next[k/3][k%3]) * PW'(r_coef[k])) >>> FRAC_BITS);
    end
    r_s1_bias <= r_bias;
  end

  always_comb begin
    w_sum = SW'(r_s1_bias);
    for (int k = 0; k < 9; k++) begin
      w_sum = w_sum + r_prod[k];
    end
    if (w_sum[SW-1]) begin
      w_result = '0;
    end else if (w_sum > L_MAX) begin
      w_result = L_MAX[DATA_WIDTH-1:0];
    end else begin
      w_result = w_sum[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      DATA_OUT       <= '0;
      data_valid_out <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      data_valid_out <= r_s1_valid;
      frame_done     <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        DATA_OUT <= w_result;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream on a 4x4 image: directed kernel table plus random
// frames, scored against a window-arithmetic reference model.
module tb_conv3x3_stream;
  import cnn_pkg::*;

  localparam int DW = 32;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int FB = 16;
  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] NEG = 32'hFFFF_0000;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          data_valid_in;
  logic [DW-1:0] DATA_IN;
  logic          W_WE;
  logic [3:0]    W_ADDR;
  logic [DW-1:0] W_DATA;
  logic [DW-1:0] DATA_OUT;
  logic          data_valid_out;
  logic          frame_done;

  conv3x3_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .FRAC_BITS(FB)) dut (
    .CLK(CLK), .RST_N(RST_N), .data_valid_in(data_valid_in), .DATA_IN(DATA_IN),
    .W_WE(W_WE), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
    .DATA_OUT(DATA_OUT), .data_valid_out(data_valid_out), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] val;
    bit          last;
    int          cyc;
  } expT;

  typedef struct {
    logic [8:0][31:0] w;
    logic [31:0]      bias;
    int               pixMode;
    int               gaps;
    logic [3:0][31:0] exp;
  } vecT;

  expT              expQ[$];
  logic [31:0]      gotQ[$];
  vecT              vecs[6];
  logic [31:0]      img[IH][IW];
  logic [8:0][31:0] curW;
  logic [31:0]      curBias;
  logic [8:0][31:0] rw;
  int tests = 0;
  int fails = 0;
  int fdCount = 0;
  int cyc = 0;
  int tbRow = 0;
  int tbCol = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint sext36(input longint x);
    return (x <<< 28) >>> 28;
  endfunction

  // Reference: plain window arithmetic over the stored image.
  function automatic logic [31:0] refConv(input int r, input int c);
    longint acc = 0;
    longint p;
    longint s;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        p = longint'($signed(img[r-2+i][c-2+j])) * longint'($signed(curW[i*3+j]));
        acc += sext36(p >>> FB);
      end
    acc += longint'($signed(curBias));
    s = sext36(acc);
    if (s < 0) return 32'd0;
    if (s > SAT_MAX) return 32'(SAT_MAX);
    return 32'(s);
  endfunction

  always @(negedge CLK) begin
    if (data_valid_out) begin
      expT e;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedStrobe", 64'(DATA_OUT), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("dataOut", 64'(DATA_OUT), 64'(e.val));
        checkOutput("frameDone", 64'(frame_done), 64'(e.last));
        checkOutput("strobeCycle", 64'(cyc), 64'(e.cyc));
      end
      gotQ.push_back(DATA_OUT);
    end else if (frame_done) begin
      checkOutput("frameDoneAlone", 64'(frame_done), 64'd0);
    end
    if (frame_done) fdCount++;
  end

  task automatic resetDut();
    RST_N = 1'b0;
    data_valid_in = 1'b0;
    W_WE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    expQ.delete();
    tbRow = 0;
    tbCol = 0;
    curW = '0;
    curBias = '0;
  endtask

  task automatic checkReset();
    checkOutput("resetDataOut", 64'(DATA_OUT), 64'd0);
    checkOutput("resetValid", 64'(data_valid_out), 64'd0);
    checkOutput("resetFrameDone", 64'(frame_done), 64'd0);
  endtask

  task automatic writeCoef(input logic [3:0] addr, input logic [31:0] data);
    W_WE = 1'b1;
    W_ADDR = addr;
    W_DATA = data;
    @(posedge CLK);
    #1;
    W_WE = 1'b0;
    if (addr < 4'd9) curW[addr] = data;
    else if (addr == W_ADDR_BIAS) curBias = data;
  endtask

  task automatic loadKernel(input logic [8:0][31:0] w, input logic [31:0] bias);
    for (int k = 0; k < 9; k++) writeCoef(4'(k), w[k]);
    writeCoef(W_ADDR_BIAS, bias);
    writeCoef(4'd12, 32'h1234_5678);
  endtask

  task automatic applyStimulus(input logic [31:0] pix, input bit vld);
    expT e;
    data_valid_in = vld;
    DATA_IN = pix;
    if (vld) begin
      img[tbRow][tbCol] = pix;
      if (tbRow >= 2 && tbCol >= 2) begin
        e.val = refConv(tbRow, tbCol);
        e.last = (tbRow == IH-1) && (tbCol == IW-1);
        e.cyc = cyc + 2;
        expQ.push_back(e);
      end
      if (tbCol == IW-1) begin
        tbCol = 0;
        tbRow = (tbRow == IH-1) ? 0 : tbRow + 1;
      end else begin
        tbCol++;
      end
    end
    @(posedge CLK);
    #1;
    data_valid_in = 1'b0;
  endtask

  task automatic streamFrame(input int mode, input int gaps);
    logic [31:0] pix;
    for (int idx = 0; idx < IW*IH; idx++) begin
      if (gaps == 1 && idx inside {1, 4, 6, 8, 13})
        repeat (3) applyStimulus(32'hDEAD_BEEF, 1'b0);
      else if (gaps == 2 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) applyStimulus($urandom, 1'b0);
      case (mode)
        0: pix = 32'(idx) << 16;
        1: pix = 32'h7FFF_0000;
        default: pix = $urandom;
      endcase
      applyStimulus(pix, 1'b1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
      @(posedge CLK);
      #1;
    end
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("drainPending", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int fd0;
    DATA_IN = '0;
    W_ADDR = '0;
    W_DATA = '0;
    W_WE = 1'b0;
    data_valid_in = 1'b0;

    for (int v = 0; v < 6; v++) begin
      vecs[v].w = '0;
      vecs[v].bias = '0;
      vecs[v].pixMode = 0;
      vecs[v].gaps = 0;
    end
    vecs[0].w[4] = ONE;
    vecs[0].exp = {32'h000A_0000, 32'h0009_0000, 32'h0006_0000, 32'h0005_0000};
    for (int k = 0; k < 9; k++) vecs[1].w[k] = ONE;
    vecs[1].exp = {32'h005A_0000, 32'h0051_0000, 32'h0036_0000, 32'h002D_0000};
    vecs[2].w[4] = ONE;
    vecs[2].bias = NEG;
    vecs[2].exp = {32'h0009_0000, 32'h0008_0000, 32'h0005_0000, 32'h0004_0000};
    vecs[3].w[4] = NEG;
    vecs[3].exp = '0;
    for (int k = 0; k < 9; k++) vecs[4].w[k] = ONE;
    vecs[4].pixMode = 1;
    vecs[4].exp = {4{32'h7FFF_FFFF}};
    vecs[5].w[4] = ONE;
    vecs[5].gaps = 1;
    vecs[5].exp = vecs[0].exp;

    resetDut();
    checkReset();

    for (int v = 0; v < 6; v++) begin
      loadKernel(vecs[v].w, vecs[v].bias);
      gotQ.delete();
      fd0 = fdCount;
      streamFrame(vecs[v].pixMode, vecs[v].gaps);
      drain();
      checkOutput($sformatf("vec%0d_strobes", v), 64'(gotQ.size()), 64'd4);
      checkOutput($sformatf("vec%0d_frameDones", v), 64'(fdCount - fd0), 64'd1);
      for (int i = 0; i < 4 && i < gotQ.size(); i++)
        checkOutput($sformatf("vec%0d_out%0d", v, i), 64'(gotQ[i]), 64'(vecs[v].exp[i]));
    end

    resetDut();
    checkReset();

    // Reset mid-frame: coefficients cleared, counters restart at (0,0).
    loadKernel(vecs[0].w, vecs[0].bias);
    for (int i = 0; i < 7; i++) applyStimulus(32'(i) << 16, 1'b1);
    resetDut();
    checkReset();
    gotQ.delete();
    streamFrame(0, 0);
    drain();
    checkOutput("clearedCoefStrobes", 64'(gotQ.size()), 64'd4);
    for (int i = 0; i < 4 && i < gotQ.size(); i++)
      checkOutput($sformatf("clearedCoef_out%0d", i), 64'(gotQ[i]), 64'd0);
    loadKernel(vecs[0].w, vecs[0].bias);
    gotQ.delete();
    streamFrame(0, 0);
    drain();
    checkOutput("afterResetStrobes", 64'(gotQ.size()), 64'd4);
    for (int i = 0; i < 4 && i < gotQ.size(); i++)
      checkOutput($sformatf("afterReset_out%0d", i), 64'(gotQ[i]), 64'(vecs[0].exp[i]));

    // Two frames with no idle cycle between them.
    gotQ.delete();
    fd0 = fdCount;
    streamFrame(0, 0);
    streamFrame(0, 0);
    drain();
    checkOutput("backToBackStrobes", 64'(gotQ.size()), 64'd8);
    checkOutput("backToBackFrameDones", 64'(fdCount - fd0), 64'd2);
    for (int i = 0; i < 8 && i < gotQ.size(); i++)
      checkOutput($sformatf("backToBack_out%0d", i), 64'(gotQ[i]), 64'(vecs[0].exp[i%4]));

    // Random kernels, pixels and valid gaps against the reference model.
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 9; k++)
        rw[k] = (f == 0) ? $urandom : ($urandom_range(0, 32'h3FFFF) - 32'h20000);
      loadKernel(rw, (f == 0) ? $urandom : ($urandom_range(0, 32'h7FFFF) - 32'h40000));
      gotQ.delete();
      streamFrame(2, 2);
      drain();
      checkOutput($sformatf("rand%0d_strobes", f), 64'(gotQ.size()), 64'd4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming 3×3 convolution stage with bias, saturation and ReLU, placed directly upstream of the 2×2 max-pooling stage. It takes one raster-scan pixel per accepted cycle, forms the 3×3 window from two line buffers, and emits one "valid" (unpadded) convolution result per complete window. Its output pair `DATA_OUT`/`data_valid_out` connects straight to the pooling stage's `DATA_IN`/`data_valid_in`.

## Interface
- `DATA_WIDTH`, 32: pixel, weight and result width; signed fixed point.
- `IMG_WIDTH`, 32: input pixels per row (≥3).
- `IMG_HEIGHT`, 32: input rows per frame (≥3).
- `FRAC_BITS`, 16: fractional bits of the shared Q format.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `data_valid_in` in 1: `DATA_IN` is accepted this cycle.
- `DATA_IN` in `DATA_WIDTH`: signed input pixel.
- `W_WE` in 1: coefficient write strobe.
- `W_ADDR` in 4: 0–8 select weight (row-major: 0 = top-left, 4 = centre); 9 selects bias; 10–15 are ignored.
- `W_DATA` in `DATA_WIDTH`: signed coefficient value.
- `DATA_OUT` out `DATA_WIDTH`: ReLU'd convolution result.
- `data_valid_out` out 1: one-cycle strobe; `DATA_OUT` is valid.
- `frame_done` out 1: asserts together with the last `data_valid_out` of a frame.

## Operation
- Column counter `col` (0..IMG_WIDTH-1) and row counter `row` (0..IMG_HEIGHT-1) advance only on accepted pixels. `col` wraps to 0 and increments `row`. At (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
- Line buffers and window registers shift only when a pixel is accepted. With `data_valid_in` low, all window state and counters hold.
- A window is complete when the accepted pixel has `row ≥ 2` and `col ≥ 2`. Output size is (IMG_WIDTH-2) × (IMG_HEIGHT-2). Partial windows produce nothing, so no padding is applied.
- Arithmetic:
  - Each product is full precision (2·`DATA_WIDTH`) and is arithmetically shifted right by `FRAC_BITS`.
  - The nine products and the sign-extended bias are summed at `DATA_WIDTH`+4 bits.
  - The sum saturates to [0x80000000, 0x7FFFFFFF] (for `DATA_WIDTH` = 32).
  - ReLU is then applied: negative results become 0.
- Coefficient registers reset to 0. A `W_WE` write lands at the clock edge and affects windows entering stage 1 on later cycles. Coefficients are changed only between frames; mid-frame results are undefined but must not hang the block.
- Reset (any time, including mid-frame) clears the counters, pipeline valid bits, `DATA_OUT`, `data_valid_out`, `frame_done` and all coefficients. The next accepted pixel is treated as (0,0). Stale line-buffer data is never used, because window gating comes from the counters.

## Timing
- Reset values: `DATA_OUT` = 0, `data_valid_out` = 0, `frame_done` = 0.
- Two-stage pipeline:
  - Stage 1 registers the nine shifted products, the bias and the window-valid flag.
  - Stage 2 registers the saturated, ReLU'd sum into `DATA_OUT` and drives `data_valid_out`.
- Latency: the completing pixel is accepted on cycle N, so `data_valid_out` is high on cycle N+2.
- The pipeline advances every cycle regardless of `data_valid_in`. Throughput is one result per accepted pixel. There is no backpressure; the consumer must always accept.
- `data_valid_out` is high for exactly one cycle per window and is never high otherwise.
- `frame_done` is high on the same cycle as the output for window (IMG_HEIGHT-1, IMG_WIDTH-1).
- A new frame's pixels may follow the last pixel back-to-back, with no idle cycle required.

## Structure
- Shared package `cnn_pkg` holds:
  - `FRAC_BITS` default, plus the `ONE_Q` constant (1 << `FRAC_BITS`).
  - Signed saturation limits `SAT_MAX` and `SAT_MIN` for `DATA_WIDTH`.
  - Coefficient address constants `W_ADDR_BIAS` (9) and `W_ADDR_CENTRE` (4).
- Sub-module `conv_line_buffer`: an enable-gated shift register of depth `IMG_WIDTH` × `DATA_WIDTH`. It is instantiated twice, for row-1 and row-2 delay.
- Everything else lives in `conv3x3_stream`: counters, window registers, coefficient file, MAC pipeline and saturation/ReLU.

## Test plan
All scenarios use `IMG_WIDTH` = `IMG_HEIGHT` = 4 and `FRAC_BITS` = 16. Pixel (r,c) = (4r+c)·0x10000.
- Identity kernel (w4 = 0x00010000, others 0, bias 0), continuous valid → 4 strobes, values 5, 6, 9, 10 (×0x10000). Each strobe arrives 2 cycles after pixels (2,2), (2,3), (3,2), (3,3). `frame_done` is high with the 4th strobe only.
- All-ones kernel (all w = 0x10000) → 45, 54, 81, 90 (×0x10000). Identity kernel with bias 0xFFFF0000 → 4, 5, 8, 9.
- Centre weight −1.0 (0xFFFF0000) → four strobes, all `DATA_OUT` = 0 (ReLU). All-ones kernel with every pixel 0x7FFF0000 → all outputs 0x7FFFFFFF (saturation).
- Identity kernel, `data_valid_in` dropped for 3 cycles at several points mid-row and at a row wrap → same four values in order, exactly 4 strobes.
- Reset asserted after 7 pixels, coefficients reloaded, full frame streamed → exactly 4 strobes, identical to the first scenario.
- Two frames back-to-back with no idle cycle → 8 strobes, `frame_done` pulses twice, and the second frame's values match the first's.
